// File: rtl/median_pkg.sv
// Shared types for the median filter front end: pixel type, window generator
// FSM states and the neighbour slot order expected by the 8-input sorter.
package median_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // Sorter input slots, raster order around the centre.
    localparam int N_TL  = 0;
    localparam int N_T   = 1;
    localparam int N_TR  = 2;
    localparam int N_L   = 3;
    localparam int N_R   = 4;
    localparam int N_BL  = 5;
    localparam int N_B   = 6;
    localparam int N_BR  = 7;
    localparam int N_NBR = 8;

endpackage

// File: rtl/median_line_buf.sv
// One line of pixel history: single port addressed by column, the read returns
// the stored value while the same cycle's write replaces it.
module median_line_buf
    import median_pkg::*;
#(
    parameter int IMG_W = 640,
    localparam int AW = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    pixel_t mem [IMG_W];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator for the median sorter. Define
// MEDIAN_WIN_REG_EN to add an output register stage on the window outputs.
module median_window_gen
    import median_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic          win_valid,
    output logic [7:0]    n1,
    output logic [7:0]    n2,
    output logic [7:0]    n3,
    output logic [7:0]    n4,
    output logic [7:0]    n5,
    output logic [7:0]    n6,
    output logic [7:0]    n7,
    output logic [7:0]    n8,
    output logic [7:0]    ctr,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          frame_done,
    output logic          frame_err
);

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;

    logic            accept;
    logic            restart;
    logic [CW-1:0]   cur_col;
    logic [RW-1:0]   cur_row;
    logic            last_col;
    logic            last_row;
    logic            emit;
    pixel_t          lb0_rd;
    pixel_t          lb1_rd;

    pixel_t          win_p0 [3][3];
    logic            vld_p0;
    logic            done_p0;
    logic            err_p0;
    logic [RW-1:0]   row_p0;
    logic [CW-1:0]   col_p0;
    pixel_t          nbr_p0 [N_NBR];

    // A sof pixel is always position (0,0), whatever the counters say.
    assign restart  = pix_valid && sof;
    assign accept   = pix_valid && (sof || (state != S_IDLE));
    assign cur_col  = restart ? '0 : col;
    assign cur_row  = restart ? '0 : row;
    assign last_col = (cur_col == CW'(IMG_W - 1));
    assign last_row = (cur_row == RW'(IMG_H - 1));
    assign emit     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    median_line_buf #(.IMG_W(IMG_W)) lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (pix_in),
        .rdata (lb0_rd)
    );

    median_line_buf #(.IMG_W(IMG_W)) lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // ---- stage p0: counters, FSM and window shift on each accepted pixel ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            col     <= '0;
            row     <= '0;
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
            err_p0  <= 1'b0;
            row_p0  <= '0;
            col_p0  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_p0[r][c] <= '0;
                end
            end
        end else begin
            err_p0  <= pix_valid && !sof && (state == S_IDLE);
            vld_p0  <= emit;
            done_p0 <= emit && last_row && last_col;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_p0[r][0] <= win_p0[r][1];
                    win_p0[r][1] <= win_p0[r][2];
                end
                win_p0[0][2] <= lb1_rd;
                win_p0[1][2] <= lb0_rd;
                win_p0[2][2] <= pix_in;

                if (emit) begin
                    row_p0 <= cur_row - RW'(1);
                    col_p0 <= cur_col - CW'(1);
                end

                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end

                if (last_col && last_row) begin
                    state <= S_IDLE;
                end else if ((cur_row >= RW'(2)) || ((cur_row == RW'(1)) && last_col)) begin
                    state <= S_STREAM;
                end else begin
                    state <= S_FILL;
                end
            end
        end
    end

    always_comb begin
        nbr_p0[N_TL] = win_p0[0][0];
        nbr_p0[N_T]  = win_p0[0][1];
        nbr_p0[N_TR] = win_p0[0][2];
        nbr_p0[N_L]  = win_p0[1][0];
        nbr_p0[N_R]  = win_p0[1][2];
        nbr_p0[N_BL] = win_p0[2][0];
        nbr_p0[N_B]  = win_p0[2][1];
        nbr_p0[N_BR] = win_p0[2][2];
    end

    assign frame_err = err_p0;

`ifdef MEDIAN_WIN_REG_EN
    logic            vld_p1;
    logic            done_p1;
    logic [RW-1:0]   row_p1;
    logic [CW-1:0]   col_p1;
    pixel_t          ctr_p1;
    pixel_t          nbr_p1 [N_NBR];

    // ---- stage p1: optional output register, loaded only with emitted windows ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            row_p1  <= '0;
            col_p1  <= '0;
            ctr_p1  <= '0;
            for (int i = 0; i < N_NBR; i++) begin
                nbr_p1[i] <= '0;
            end
        end else begin
            vld_p1  <= vld_p0;
            done_p1 <= done_p0;
            if (vld_p0) begin
                row_p1 <= row_p0;
                col_p1 <= col_p0;
                ctr_p1 <= win_p0[1][1];
                for (int i = 0; i < N_NBR; i++) begin
                    nbr_p1[i] <= nbr_p0[i];
                end
            end
        end
    end

    assign win_valid  = vld_p1;
    assign frame_done = done_p1;
    assign win_row    = row_p1;
    assign win_col    = col_p1;
    assign ctr        = ctr_p1;
    assign n1         = nbr_p1[N_TL];
    assign n2         = nbr_p1[N_T];
    assign n3         = nbr_p1[N_TR];
    assign n4         = nbr_p1[N_L];
    assign n5         = nbr_p1[N_R];
    assign n6         = nbr_p1[N_BL];
    assign n7         = nbr_p1[N_B];
    assign n8         = nbr_p1[N_BR];
`else
    assign win_valid  = vld_p0;
    assign frame_done = done_p0;
    assign win_row    = row_p0;
    assign win_col    = col_p0;
    assign ctr        = win_p0[1][1];
    assign n1         = nbr_p0[N_TL];
    assign n2         = nbr_p0[N_T];
    assign n3         = nbr_p0[N_TR];
    assign n4         = nbr_p0[N_L];
    assign n5         = nbr_p0[N_R];
    assign n6         = nbr_p0[N_BL];
    assign n7         = nbr_p0[N_B];
    assign n8         = nbr_p0[N_BR];
`endif

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen on a 5x4 frame using ramp images.
module tb_median_window_gen;

`ifdef MEDIAN_WIN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic       win_valid;
    logic [7:0] n1, n2, n3, n4, n5, n6, n7, n8, ctr;
    logic [1:0] win_row;
    logic [2:0] win_col;
    logic       frame_done;
    logic       frame_err;

    typedef struct packed {
        logic [7:0]  n1, n2, n3, n4, n5, n6, n7, n8, ctr;
        logic [1:0]  row;
        logic [2:0]  col;
        logic        done;
        logic [31:0] cyc;
    } win_t;

    win_t got_q[$];
    win_t exp_q[$];
    int   cyc = 0;
    int   err_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    median_window_gen #(.IMG_W(5), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win_valid(win_valid), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5),
        .n6(n6), .n7(n7), .n8(n8), .ctr(ctr), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (win_valid)
            got_q.push_back('{n1, n2, n3, n4, n5, n6, n7, n8, ctr, win_row, win_col, frame_done, 32'(cyc)});
        if (frame_err)
            err_cnt++;
    end

    function automatic win_t mk_win(input int base, input int r, input int c, input logic done, input int at);
        int v;
        v = base + 10 * r + c;
        return '{8'(v - 11), 8'(v - 10), 8'(v - 9), 8'(v - 1), 8'(v + 1), 8'(v + 9),
                 8'(v + 10), 8'(v + 11), 8'(v), 2'(r), 3'(c), done, 32'(at)};
    endfunction

    task automatic drive(input logic [7:0] p, input logic s, input int gaps, output int acc);
        repeat (gaps) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof = 1'b0;
        end
        @(negedge clk);
        pix_in = p;
        pix_valid = 1'b1;
        sof = s;
        acc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof = 1'b0;
        end
    endtask

    // Sends the first npix pixels of a ramp frame, sof on the first one.
    task automatic send_frame(input int base, input int gap_max, input int npix);
        int acc;
        for (int i = 0; i < npix; i++) begin
            int r, c;
            r = i / 5;
            c = i % 5;
            drive(8'(base + 10 * r + c), i == 0, $urandom_range(0, gap_max), acc);
            if (r >= 2 && c >= 2)
                exp_q.push_back(mk_win(base, r - 1, c - 1, (r == 3 && c == 4), acc + LAT - 1));
        end
    endtask

    task automatic compare_all(input string tag);
        checks++;
        assert (got_q.size() == exp_q.size()) else begin
            errors++;
            $error("FAIL %s_count observed=%0d expected=%0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            assert (got_q[i] === exp_q[i]) else begin
                errors++;
                $error("FAIL %s_win%0d observed=%h expected=%h", tag, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({win_valid, n1, n2, n3, n4, n5, n6, n7, n8, ctr, win_row, win_col, frame_done, frame_err} === 80'd0) else begin
            errors++;
            $error("FAIL %s observed=%h expected=0", tag,
                   {win_valid, n1, n2, n3, n4, n5, n6, n7, n8, ctr, win_row, win_col, frame_done, frame_err});
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int acc;
        win_t first_w;

        // Reset state.
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b1;
        idle(2);

        // Contiguous ramp frame.
        send_frame(0, 0, 20);
        idle(4);
        check_int("frame1_windows", got_q.size(), 6);
        first_w = (got_q.size() > 0) ? got_q[0] : '0;
        checks++;
        assert (first_w[109:32] === {8'd0, 8'd1, 8'd2, 8'd10, 8'd12, 8'd20, 8'd21, 8'd22, 8'd11, 2'd1, 3'd1, 1'b0}) else begin
            errors++;
            $error("FAIL first_window observed=%h expected=%h", first_w[109:32],
                   {8'd0, 8'd1, 8'd2, 8'd10, 8'd12, 8'd20, 8'd21, 8'd22, 8'd11, 2'd1, 3'd1, 1'b0});
        end
        compare_all("contig");
        check_int("no_err_contig", err_cnt, 0);

        // Same frame with random input gaps.
        send_frame(0, 2, 20);
        idle(4);
        compare_all("gaps");

        // Pixels without sof while idle are dropped and flagged.
        err_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(8'(50 + i), 1'b0, 1, acc);
        end
        idle(4);
        check_int("idle_err_pulses", err_cnt, 3);
        check_int("idle_no_windows", got_q.size(), 0);
        got_q.delete();

        // sof at pixel (2,3) restarts with a new ramp.
        err_cnt = 0;
        send_frame(0, 0, 13);
        send_frame(100, 0, 20);
        idle(4);
        compare_all("restart");

        // sof on the last pixel: no window or frame_done for it, new frame starts there.
        send_frame(0, 0, 19);
        send_frame(0, 0, 20);
        idle(4);
        compare_all("sof_last");
        check_int("no_err_restart", err_cnt, 0);

        // Asynchronous reset mid-stream.
        send_frame(0, 0, 14);
        @(negedge clk);
        pix_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("async_reset_outputs");
        @(negedge clk);
        check_zero("reset_hold_outputs");
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        idle(2);
        err_cnt = 0;
        drive(8'd7, 1'b0, 0, acc);
        idle(3);
        check_int("post_reset_needs_sof", err_cnt, 1);
        send_frame(0, 0, 20);
        idle(4);
        compare_all("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
